// File: rtl/gray_capture_ctrl.sv
// Gray pixel capture sequencer: arm, frame sync, pair packing, FIFO handoff.
// Optional crop window enabled by defining GRAY_CAPTURE_CROP_EN.
module gray_capture_ctrl #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
`ifdef GRAY_CAPTURE_CROP_EN
  ,
  parameter int CROP_X0 = 0,
  parameter int CROP_X1 = 799,
  parameter int CROP_Y0 = 0,
  parameter int CROP_Y1 = 479
`endif
) (
  input  logic        iCLK,
  input  logic        iReset_n,
  input  logic        iStart,
  input  logic        iAbort,
  input  logic [7:0]  iFrames,
  input  logic [7:0]  iGray,
  input  logic        iDval,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  output logic [15:0] oWrData,
  output logic        oWrValid,
  input  logic        iWrReady,
  output logic        oBusy,
  output logic        oDone,
  output logic        oOverflow,
  output logic [7:0]  oFrameCnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    FLUSH,
    DRAIN
  } state_t;

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

  state_t      state;
  state_t      stNext;
  logic [7:0]  framesLat;
  logic [7:0]  holdByte;
  logic        halfFull;
  logic        lastFrame;

  logic        sof;
  logic        eof;
  logic        inWin;
  logic        live;
  logic        take;
  logic        flushing;
  logic        newWord;
  logic [15:0] newData;
  logic        halfNext;
  logic        lastNow;

  always_comb begin
    sof = iDval && iX_Cont == 16'd0
      && iY_Cont == 16'd0;
    eof = iDval && iX_Cont == X_LAST
      && iY_Cont == Y_LAST;
`ifdef GRAY_CAPTURE_CROP_EN
    inWin = iX_Cont >= 16'(CROP_X0)
      && iX_Cont <= 16'(CROP_X1)
      && iY_Cont >= 16'(CROP_Y0)
      && iY_Cont <= 16'(CROP_Y1);
`else
    inWin = 1'b1;
`endif
    // The SOF pixel itself is captured while leaving WAIT_SOF
    live = (state == CAPTURE)
      || (state == WAIT_SOF && sof);
    take = live && iDval && inWin;
    flushing = (state == FLUSH);
    newWord = (take && halfFull) || flushing;
    newData = flushing ? {8'h00, holdByte}
                       : {iGray, holdByte};
    halfNext = take ? !halfFull
             : (flushing ? 1'b0 : halfFull);
    lastNow = (framesLat != 8'd0)
      && (oFrameCnt + 8'd1 == framesLat);
    stNext = state;
    unique case (state)
      IDLE: begin
        if (iStart) stNext = WAIT_SOF;
      end
      WAIT_SOF, CAPTURE: begin
        if (live && eof) begin
          if (halfNext) stNext = FLUSH;
          else if (lastNow) stNext = DRAIN;
          else stNext = WAIT_SOF;
        end else if (live) begin
          stNext = CAPTURE;
        end
      end
      FLUSH: begin
        stNext = lastFrame ? DRAIN : WAIT_SOF;
      end
      DRAIN: begin
        if (!oWrValid) stNext = IDLE;
      end
      default: stNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iReset_n) begin
    if (!iReset_n) begin
      state     <= IDLE;
      oWrData   <= '0;
      oWrValid  <= 1'b0;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oOverflow <= 1'b0;
      oFrameCnt <= '0;
      framesLat <= '0;
      holdByte  <= '0;
      halfFull  <= 1'b0;
      lastFrame <= 1'b0;
    end else if (iAbort) begin
      state    <= IDLE;
      oWrValid <= 1'b0;
      halfFull <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      state <= stNext;
      oBusy <= stNext inside {WAIT_SOF, CAPTURE, FLUSH};
      oDone <= (state == DRAIN) && !oWrValid;
      halfFull <= halfNext;
      if (take && !halfFull) holdByte <= iGray;
      if (state == IDLE && iStart) begin
        framesLat <= iFrames;
        oFrameCnt <= '0;
        oOverflow <= 1'b0;
        lastFrame <= 1'b0;
      end
      if (live && eof) begin
        oFrameCnt <= oFrameCnt + 8'd1;
        lastFrame <= lastNow;
      end
      // A stalled slot keeps its word; the newcomer is dropped
      if (newWord && oWrValid && !iWrReady) begin
        oOverflow <= 1'b1;
      end else if (newWord) begin
        oWrData  <= newData;
        oWrValid <= 1'b1;
      end else if (oWrValid && iWrReady) begin
        oWrValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_capture_ctrl.sv
// Bench for gray_capture_ctrl: vector table, scripted corners, random frames.
// Small 8x4 frame geometry keeps the run short.
module tb_gray_capture_ctrl;
  localparam int H = 8;
  localparam int V = 4;
`ifdef GRAY_CAPTURE_CROP_EN
  localparam int CX0 = 1;
  localparam int CX1 = 3;
  localparam int CY0 = 0;
  localparam int CY1 = 0;
`endif

  logic        iCLK = 1'b0;
  logic        iReset_n = 1'b0;
  logic        iStart = 1'b0;
  logic        iAbort = 1'b0;
  logic [7:0]  iFrames = '0;
  logic [7:0]  iGray = '0;
  logic        iDval = 1'b0;
  logic [15:0] iX_Cont = '0;
  logic [15:0] iY_Cont = '0;
  logic        iWrReady = 1'b1;
  logic [15:0] oWrData;
  logic        oWrValid;
  logic        oBusy;
  logic        oDone;
  logic        oOverflow;
  logic [7:0]  oFrameCnt;

  always #5 iCLK = ~iCLK;

  gray_capture_ctrl #(
    .H_ACTIVE(H),
    .V_ACTIVE(V)
`ifdef GRAY_CAPTURE_CROP_EN
    ,
    .CROP_X0(CX0),
    .CROP_X1(CX1),
    .CROP_Y0(CY0),
    .CROP_Y1(CY1)
`endif
  ) dut (
    .iCLK(iCLK),
    .iReset_n(iReset_n),
    .iStart(iStart),
    .iAbort(iAbort),
    .iFrames(iFrames),
    .iGray(iGray),
    .iDval(iDval),
    .iX_Cont(iX_Cont),
    .iY_Cont(iY_Cont),
    .oWrData(oWrData),
    .oWrValid(oWrValid),
    .iWrReady(iWrReady),
    .oBusy(oBusy),
    .oDone(oDone),
    .oOverflow(oOverflow),
    .oFrameCnt(oFrameCnt)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  // Reference: capture phase flags plus a byte queue of pending pixels
  bit          mArmed, mCap, mFlush, mDrain, mLast;
  bit          mValid, mOvf, mDone, mBusy;
  logic [15:0] mData = '0;
  logic [7:0]  mTgt = '0;
  logic [7:0]  mCnt = '0;
  logic [7:0]  q[$];
  int          acc = 0;
  logic [15:0] firstW = '0;
  int          doneSeen = 0;
  bit          gRand = 1'b0;

  task automatic modelReset();
    mArmed = 0; mCap = 0; mFlush = 0;
    mDrain = 0; mLast = 0; mValid = 0;
    mOvf = 0; mDone = 0; mBusy = 0;
    mData = '0; mTgt = '0; mCnt = '0;
    q.delete();
  endtask

  task automatic modelEdge();
    bit sof, eof, win, newW, dn;
    logic [15:0] w;
    logic [7:0] nc;
    int x, y;
    x = int'(iX_Cont);
    y = int'(iY_Cont);
    sof = iDval && x == 0 && y == 0;
    eof = iDval && x == H - 1 && y == V - 1;
`ifdef GRAY_CAPTURE_CROP_EN
    win = x >= CX0 && x <= CX1 && y >= CY0 && y <= CY1;
`else
    win = 1'b1;
`endif
    newW = 0; dn = 0; w = '0;
    if (iAbort) begin
      mArmed = 0; mCap = 0; mFlush = 0; mDrain = 0;
      q.delete(); mValid = 0; mDone = 0; mBusy = 0;
      return;
    end
    if (mDrain) begin
      if (!mValid) begin mDrain = 0; dn = 1; end
    end else if (mFlush) begin
      w = {8'h00, q[0]}; q.delete(); newW = 1;
      mFlush = 0;
      if (mLast) mDrain = 1; else mArmed = 1;
    end else if (mCap || (mArmed && sof)) begin
      mArmed = 0; mCap = 1;
      if (iDval && win) begin
        q.push_back(iGray);
        if (q.size() == 2) begin
          w = {q[1], q[0]}; q.delete(); newW = 1;
        end
      end
      if (eof) begin
        nc = mCnt + 8'd1;
        mLast = (mTgt != 0) && (nc == mTgt);
        mCnt = nc; mCap = 0;
        if (q.size() == 1) mFlush = 1;
        else if (mLast) mDrain = 1;
        else mArmed = 1;
      end
    end else if (!mArmed && iStart) begin
      mTgt = iFrames; mCnt = 0; mOvf = 0;
      mLast = 0; mArmed = 1;
    end
    if (newW) begin
      if (mValid && !iWrReady) mOvf = 1;
      else begin mData = w; mValid = 1; end
    end else if (mValid && iWrReady) begin
      mValid = 0;
    end
    mDone = dn;
    mBusy = mArmed || mCap || mFlush;
  endtask

  task automatic check();
    chk("valid", 32'(oWrValid), 32'(mValid));
    if (mValid) chk("data", 32'(oWrData), 32'(mData));
    chk("busy", 32'(oBusy), 32'(mBusy));
    chk("done", 32'(oDone), 32'(mDone));
    chk("ovf", 32'(oOverflow), 32'(mOvf));
    chk("cnt", 32'(oFrameCnt), 32'(mCnt));
    if (oDone) doneSeen++;
  endtask

  task automatic step();
    if (oWrValid && iWrReady) begin
      acc++;
      if (acc == 1) firstW = oWrData;
    end
    @(posedge iCLK);
    modelEdge();
    @(negedge iCLK);
    check();
    iStart = 0;
    iAbort = 0;
  endtask

  task automatic pix(input int x, input int y,
                     input bit dv, input bit rdy);
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iDval = dv;
    iGray = gRand ? 8'($urandom) : 8'(x);
    iWrReady = rdy;
    step();
  endtask

  task automatic idle(input int n, input bit rnd);
    repeat (n) pix(0, 1, 0, rnd ? 1'($urandom) : 1'b1);
  endtask

  task automatic runFrame(input int y0, input int startAt,
                          input int lowN, input bit rnd);
    int idx;
    idx = 0;
    gRand = rnd;
    for (int y = y0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (rnd) repeat ($urandom_range(0, 2))
          pix(x, y, 0, 1'($urandom));
        if (idx == startAt) iStart = 1;
        pix(x, y, 1, rnd ? 1'($urandom) : (idx >= lowN));
        idx++;
      end
      repeat (2) pix(H, y, 0, rnd ? 1'($urandom) : 1'b1);
    end
    gRand = 0;
  endtask

  task automatic waitDone(input string nm, input int d0,
                          input int bound, input bit rnd);
    for (int k = 0; k < bound && doneSeen == d0; k++)
      idle(1, rnd);
    chk(nm, 32'(doneSeen - d0), 32'd1);
  endtask

  typedef struct {
    bit         s;
    bit         a;
    logic [7:0] f;
    bit         busy;
  } vec_t;

  vec_t tbl[10];
  int   d0;
  int   accMid;
  int   nF;

  initial begin
    modelReset();
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    chk("rst_data", 32'(oWrData), 32'h0);
    chk("rst_valid", 32'(oWrValid), 32'h0);
    chk("rst_busy", 32'(oBusy), 32'h0);
    chk("rst_done", 32'(oDone), 32'h0);
    chk("rst_ovf", 32'(oOverflow), 32'h0);
    chk("rst_cnt", 32'(oFrameCnt), 32'h0);
    iReset_n = 1;

    tbl[0] = '{0, 0, 8'd0, 0};
    tbl[1] = '{1, 1, 8'd1, 0};
    tbl[2] = '{0, 0, 8'd0, 0};
    tbl[3] = '{1, 0, 8'd2, 1};
    tbl[4] = '{1, 0, 8'd5, 1};
    tbl[5] = '{0, 0, 8'd0, 1};
    tbl[6] = '{0, 1, 8'd0, 0};
    tbl[7] = '{0, 0, 8'd0, 0};
    tbl[8] = '{1, 0, 8'd1, 1};
    tbl[9] = '{0, 1, 8'd0, 0};
    for (int i = 0; i < 10; i++) begin
      iStart = tbl[i].s;
      iAbort = tbl[i].a;
      iFrames = tbl[i].f;
      pix(0, 1, 0, 1);
      chk($sformatf("tbl%0d_busy", i),
          32'(oBusy), 32'(tbl[i].busy));
    end

    d0 = doneSeen;
    acc = 0;
    iFrames = 8'd1;
    iStart = 1;
    idle(1, 0);
    runFrame(0, -1, 0, 0);
    waitDone("B_done", d0, 10, 0);
`ifndef GRAY_CAPTURE_CROP_EN
    chk("B_words", 32'(acc), 32'd16);
    chk("B_first", 32'(firstW), 32'h0100);
    chk("B_cnt", 32'(oFrameCnt), 32'd1);
    chk("B_ovf", 32'(oOverflow), 32'd0);
`endif

    d0 = doneSeen;
    acc = 0;
    runFrame(1, 0, 0, 0);
    accMid = acc;
    chk("C_pre", 32'(accMid), 32'd0);
    runFrame(0, -1, 0, 0);
    waitDone("C_done", d0, 10, 0);
`ifndef GRAY_CAPTURE_CROP_EN
    chk("C_words", 32'(acc), 32'd16);
`endif

    d0 = doneSeen;
    acc = 0;
    iStart = 1;
    idle(1, 0);
    runFrame(0, -1, 6, 0);
    waitDone("D_done", d0, 10, 0);
`ifndef GRAY_CAPTURE_CROP_EN
    chk("D_words", 32'(acc), 32'd14);
    chk("D_first", 32'(firstW), 32'h0100);
    chk("D_ovf", 32'(oOverflow), 32'd1);
`endif
    idle(3, 0);
    chk("D_ovf_hold", 32'(oOverflow), 32'(mOvf));

    iFrames = 8'd0;
    iStart = 1;
    idle(1, 0);
    chk("E_ovf_clr", 32'(oOverflow), 32'd0);
    d0 = doneSeen;
    repeat (3) runFrame(0, -1, 0, 0);
    iAbort = 1;
    idle(1, 0);
    chk("E_cnt", 32'(oFrameCnt), 32'd3);
    chk("E_busy", 32'(oBusy), 32'd0);
    chk("E_valid", 32'(oWrValid), 32'd0);
    chk("E_nodone", 32'(doneSeen - d0), 32'd0);

    iFrames = 8'd1;
    iStart = 1;
    idle(1, 0);
    pix(0, 0, 1, 0);
    pix(1, 0, 1, 0);
    pix(2, 0, 1, 0);
    #2 iReset_n = 0;
    #1;
    chk("mr_data", 32'(oWrData), 32'h0);
    chk("mr_valid", 32'(oWrValid), 32'h0);
    chk("mr_busy", 32'(oBusy), 32'h0);
    chk("mr_cnt", 32'(oFrameCnt), 32'h0);
    chk("mr_ovf", 32'(oOverflow), 32'h0);
    @(negedge iCLK);
    iReset_n = 1;
    modelReset();
    check();

    for (int it = 0; it < 6; it++) begin
      nF = $urandom_range(1, 2);
      iFrames = 8'(nF);
      d0 = doneSeen;
      iStart = 1;
      idle(1, 1);
      repeat (nF) runFrame(0, -1, 0, 1);
      waitDone($sformatf("R%0d_done", it), d0, 60, 1);
      idle(2, 1);
    end

`ifdef GRAY_CAPTURE_CROP_EN
    d0 = doneSeen;
    acc = 0;
    iFrames = 8'd1;
    iStart = 1;
    idle(1, 0);
    runFrame(0, -1, 0, 0);
    waitDone("X_done", d0, 10, 0);
    chk("X_words", 32'(acc), 32'd2);
    chk("X_first", 32'(firstW), 32'h0201);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
